// File: rtl/nic_channel_writer.sv
// ---------------------------------------------------------------------------
// nic_channel_writer
//
// Upstream writer for a one-entry channel buffer. Words arrive from the
// processing element on a valid/ready port and are queued in a DEPTH-entry
// FIFO. The head of the FIFO is offered to the channel buffer only while the
// buffer reports not-full, so a word is never presented to a buffer that
// would drop it. Two link-monitoring counters are kept: a wrapping count of
// words sent and a saturating count of back-pressure cycles.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-low reset
//   pe_valid      PE offers pe_data this cycle
//   pe_data       word from the PE
//   pe_ready      FIFO has room (occupancy below DEPTH)
//   buf_full      full flag of the downstream channel buffer
//   buf_we        write enable to the channel buffer
//   buf_data      FIFO head word, drives the buffer's data_in
//   fifo_count    FIFO occupancy, 0..DEPTH
//   sent_count    words written to the buffer, wraps
//   stall_cycles  cycles with data waiting on a full buffer, saturates
// ---------------------------------------------------------------------------
module nic_channel_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pe_valid,
    input  logic [DATA_WIDTH-1:0]      pe_data,
    output logic                       pe_ready,
    input  logic                       buf_full,
    output logic                       buf_we,
    output logic [DATA_WIDTH-1:0]      buf_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_WIDTH-1:0]       sent_count,
    output logic [CNT_WIDTH-1:0]       stall_cycles
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [COUNT_W-1:0]   COUNT_FULL = COUNT_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] STALL_MAX  = {CNT_WIDTH{1'b1}};

    // Storage is deliberately left out of reset; only the pointers and the
    // occupancy decide which entries are meaningful.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0] sent_count_q, sent_count_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    logic push;
    logic pop;
    logic not_empty;

    // Handshake and send decisions. Both come only from registered state and
    // buf_full, so there is no combinational path from pe_valid/pe_data to
    // any output. An empty FIFO never sends, even while a word is being
    // pushed: there is no fall-through, the word appears next cycle.
    always_comb begin
        not_empty = (count_q != '0);
        pe_ready  = (count_q != COUNT_FULL);
        buf_we    = not_empty & ~buf_full;
        push      = pe_valid & pe_ready;
        pop       = buf_we;
    end

    assign buf_data     = mem_q[rd_ptr_q];
    assign fifo_count   = count_q;
    assign sent_count   = sent_count_q;
    assign stall_cycles = stall_cycles_q;

    // Next-state for pointers, occupancy and statistics. Pointers are exactly
    // PTR_W bits wide so the +1 wraps from DEPTH-1 to 0 on its own (DEPTH is
    // a power of two). A simultaneous push and pop leaves the count alone.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sent_count_d   = sent_count_q;
        stall_cycles_d = stall_cycles_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            sent_count_d = sent_count_q + CNT_WIDTH'(1);
        end

        if (push && !pop) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - COUNT_W'(1);
        end

        // A stall is a cycle where a word is waiting but the buffer is full.
        if (not_empty && buf_full && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
    end

    // Control and statistics registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sent_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sent_count_q   <= sent_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // FIFO array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pe_data;
        end
    end

endmodule

// File: tb/tb_nic_channel_writer.sv
// ---------------------------------------------------------------------------
// tb_nic_channel_writer
//
// Two writers share one stimulus stream: one with the default 16-bit
// statistics counters and one with 4-bit counters so that wrap and
// saturation are reachable quickly. A downstream channel buffer is modelled
// by the bench (full the cycle after a write, drained right away unless held
// full). A reference model built on a queue of accepted words predicts every
// output, and a negedge monitor compares the DUTs against it.
// ---------------------------------------------------------------------------
module tb_nic_channel_writer;

   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int CW4   = 4;

   logic          clk;
   logic          reset;
   logic          pe_valid;
   logic [DW-1:0] pe_data;
   logic          buf_full;

   logic          pe_ready,  pe_ready4;
   logic          buf_we,    buf_we4;
   logic [DW-1:0] buf_data,  buf_data4;
   logic [2:0]    fifo_count, fifo_count4;
   logic [CW-1:0] sent_count, stall_cycles;
   logic [CW4-1:0] sent_count4, stall_cycles4;

   int vectors;
   int miscompares;

   logic [DW-1:0] model_q [$];
   int  sent_total;
   int  stall_total;
   int  pops_seen;
   logic hold_full;
   logic last_we;
   logic last_accept;
   int  occ;
   logic exp_ready;
   logic exp_we;

   nic_channel_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .pe_valid(pe_valid), .pe_data(pe_data),
      .pe_ready(pe_ready), .buf_full(buf_full), .buf_we(buf_we),
      .buf_data(buf_data), .fifo_count(fifo_count), .sent_count(sent_count),
      .stall_cycles(stall_cycles)
   );

   nic_channel_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW4)) dut4 (
      .clk(clk), .reset(reset), .pe_valid(pe_valid), .pe_data(pe_data),
      .pe_ready(pe_ready4), .buf_full(buf_full), .buf_we(buf_we4),
      .buf_data(buf_data4), .fifo_count(fifo_count4), .sent_count(sent_count4),
      .stall_cycles(stall_cycles4)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance one cycle and update the downstream buffer's full flag: it is
   // full the cycle after a write, or permanently while hold_full is set.
   task automatic tick();
      @(posedge clk);
      #1;
      buf_full = hold_full | last_we;
   endtask

   // Drive one cycle of PE stimulus, then move on to the next cycle.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
      pe_valid = v;
      pe_data  = d;
      tick();
   endtask

   // Offer words first..first+n-1 in order, advancing only on acceptance,
   // for at most max_cycles cycles.
   task automatic pushSequence(input int first, input int n, input int max_cycles);
      int next;
      next = first;
      for (int c = 0; c < max_cycles && next < first + n; c++) begin
         applyStimulus(1'b1, DW'(next));
         if (last_accept) next++;
      end
      pe_valid = 1'b0;
   endtask

   // Stop offering and wait for the model queue to empty, bounded.
   task automatic drain();
      pe_valid  = 1'b0;
      hold_full = 1'b0;
      for (int c = 0; c < 40 && model_q.size() != 0; c++) tick();
      checkOutput("drain_done", DW'(model_q.size()), '0);
   endtask

   // Reference model and monitor. Occupancy is the length of the queue of
   // accepted words; a send happens whenever something is queued and the
   // buffer is not full, and it must carry the oldest queued word.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("rst_pe_ready",   DW'(pe_ready),     DW'(1));
         checkOutput("rst_buf_we",     DW'(buf_we),       '0);
         checkOutput("rst_fifo_count", DW'(fifo_count),   '0);
         checkOutput("rst_sent",       DW'(sent_count),   '0);
         checkOutput("rst_stall",      DW'(stall_cycles), '0);
         checkOutput("rst_buf_we4",    DW'(buf_we4),      '0);
         model_q.delete();
         sent_total  = 0;
         stall_total = 0;
         last_we     = 1'b0;
         last_accept = 1'b0;
      end else begin
         occ       = model_q.size();
         exp_ready = (occ < DEPTH);
         exp_we    = (occ > 0) && !buf_full;
         checkOutput("pe_ready",     DW'(pe_ready),    DW'(exp_ready));
         checkOutput("buf_we",       DW'(buf_we),      DW'(exp_we));
         checkOutput("fifo_count",   DW'(fifo_count),  DW'(occ));
         checkOutput("sent_count",   DW'(sent_count),  DW'(sent_total % 65536));
         checkOutput("stall_cycles", DW'(stall_cycles),
                     DW'((stall_total > 65535) ? 65535 : stall_total));
         checkOutput("pe_ready4",    DW'(pe_ready4),   DW'(exp_ready));
         checkOutput("buf_we4",      DW'(buf_we4),     DW'(exp_we));
         checkOutput("fifo_count4",  DW'(fifo_count4), DW'(occ));
         checkOutput("sent_count4",  DW'(sent_count4), DW'(sent_total % 16));
         checkOutput("stall4",       DW'(stall_cycles4),
                     DW'((stall_total > 15) ? 15 : stall_total));
         if (exp_we) begin
            checkOutput("buf_data",  buf_data,  model_q[0]);
            checkOutput("buf_data4", buf_data4, model_q[0]);
            void'(model_q.pop_front());
            sent_total++;
            pops_seen++;
         end
         if (occ > 0 && buf_full) stall_total++;
         last_accept = pe_valid && exp_ready;
         if (last_accept) model_q.push_back(pe_data);
         last_we = buf_we;
      end
   end

   initial begin
      int sent_before;
      vectors     = 0;
      miscompares = 0;
      pops_seen   = 0;
      sent_total  = 0;
      stall_total = 0;
      last_we     = 1'b0;
      last_accept = 1'b0;
      hold_full   = 1'b0;
      buf_full    = 1'b0;
      reset       = 1'b0;
      pe_valid    = 1'b1;
      pe_data     = '0;

      // Reset held with a valid offer: outputs must stay at reset values.
      for (int c = 0; c < 3; c++) tick();
      reset = 1'b1;

      // First word after reset: sent on the following edge.
      applyStimulus(1'b1, DW'(64'hA5));
      applyStimulus(1'b0, '0);
      checkOutput("first_word_sent", DW'(sent_count), DW'(1));
      drain();

      // Ten words back-to-back through a buffer drained every cycle.
      sent_before = sent_total;
      pops_seen   = 0;
      pushSequence(1, 10, 60);
      drain();
      checkOutput("ordering_pops", DW'(pops_seen), DW'(10));
      checkOutput("ordering_sent", DW'(sent_count), DW'((sent_before + 10) % 65536));

      // Buffer held full: only DEPTH of six offered words get in.
      hold_full = 1'b1;
      tick();
      pushSequence(101, 6, 10);
      checkOutput("bp_fifo_count", DW'(fifo_count), DW'(DEPTH));
      checkOutput("bp_pe_ready",   DW'(pe_ready),   '0);
      drain();

      // Two queued, then concurrent push/pop traffic with the buffer released.
      hold_full = 1'b1;
      tick();
      pushSequence(201, 2, 6);
      hold_full = 1'b0;
      pushSequence(203, 8, 40);
      drain();

      // Saturation: one word waiting on a full buffer for 20 cycles.
      hold_full = 1'b1;
      tick();
      pushSequence(301, 1, 4);
      for (int c = 0; c < 20; c++) tick();
      checkOutput("stall_saturated4", DW'(stall_cycles4), DW'(15));
      drain();

      // Randomized traffic with random back-pressure.
      for (int c = 0; c < 1500; c++) begin
         hold_full = ($urandom_range(0, 3) == 0);
         applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom});
      end
      drain();

      // Asynchronous reset with three words queued and a send pending.
      hold_full = 1'b1;
      tick();
      pushSequence(401, 3, 8);
      checkOutput("pre_reset_count", DW'(fifo_count), DW'(3));
      hold_full = 1'b0;
      buf_full  = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async_fifo_count",  DW'(fifo_count),  '0);
      checkOutput("async_buf_we",      DW'(buf_we),      '0);
      checkOutput("async_fifo_count4", DW'(fifo_count4), '0);
      tick();
      reset = 1'b1;
      pushSequence(501, 4, 20);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
